// File: rtl/decode_stage_pkg.sv
// Decode stage shared types: opcode map, control encodings, immediate formats.
// Also holds the funct3 helper lookups used by the decoder.
package decode_stage_pkg;

  localparam int ILEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_OP_NONE,
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_SLL,
    ALU_OP_SLT,
    ALU_OP_SLTU,
    ALU_OP_XOR,
    ALU_OP_SRL,
    ALU_OP_SRA,
    ALU_OP_OR,
    ALU_OP_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL1_NONE,
    SEL1_RS1,
    SEL1_PC,
    SEL1_ZERO
  } alu_sel1_e;

  typedef enum logic [1:0] {
    SEL2_NONE,
    SEL2_RS2,
    SEL2_IMM,
    SEL2_FOUR
  } alu_sel2_e;

  typedef enum logic [2:0] {
    CMP_NONE,
    CMP_EQ,
    CMP_NE,
    CMP_LT,
    CMP_GE,
    CMP_LTU,
    CMP_GEU
  } cmp_op_e;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e   alu_op;
    alu_sel1_e alu_sel1;
    alu_sel2_e alu_sel2;
    cmp_op_e   cmp_op;
    logic      branch;
    logic      jump;
    wb_sel_e   wb_sel;
    logic      wb_en;
    logic [1:0] lsu_size;
    logic      lsu_sign_ext;
    logic      lsu_we;
    logic      load;
    logic      illegal;
  } ctl_t;

  localparam ctl_t CTL_NONE = '0;

  // One row of the opcode table, including register-use columns.
  typedef struct packed {
    ctl_t     ctl;
    imm_fmt_e fmt;
    logic     uses_rs1;
    logic     uses_rs2;
  } dec_t;

  function automatic alu_op_e alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e r;
    r = ALU_OP_NONE;
    case (f3)
      3'd0: r = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'd1: r = ALU_OP_SLL;
      3'd2: r = ALU_OP_SLT;
      3'd3: r = ALU_OP_SLTU;
      3'd4: r = ALU_OP_XOR;
      3'd5: r = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'd6: r = ALU_OP_OR;
      3'd7: r = ALU_OP_AND;
      default: r = ALU_OP_NONE;
    endcase
    return r;
  endfunction

  function automatic cmp_op_e cmp_from_f3(
    input logic [2:0] f3
  );
    cmp_op_e r;
    r = CMP_NONE;
    case (f3)
      3'd0: r = CMP_EQ;
      3'd1: r = CMP_NE;
      3'd4: r = CMP_LT;
      3'd5: r = CMP_GE;
      3'd6: r = CMP_LTU;
      3'd7: r = CMP_GEU;
      default: r = CMP_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J bit layout and sign-extends to XLEN.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_inst,
  input  imm_fmt_e        i_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (i_fmt)
      IMM_I: imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S: imm32 = {{20{i_inst[31]}}, i_inst[31:25],
                      i_inst[11:7]};
      IMM_B: imm32 = {{19{i_inst[31]}}, i_inst[31],
                      i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
      IMM_U: imm32 = {i_inst[31:12], 12'b0};
      IMM_J: imm32 = {{11{i_inst[31]}}, i_inst[31],
                      i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute.
// Opcode table, load-use interlock, flush and stall counter.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_pc,
  output logic [REG_AW-1:0] o_rs1,
  output logic [REG_AW-1:0] o_rs2,
  output logic [REG_AW-1:0] o_rd,
  output logic [XLEN-1:0]   o_imm,
  output alu_op_e           o_alu_op,
  output alu_sel1_e         o_alu_sel1,
  output alu_sel2_e         o_alu_sel2,
  output cmp_op_e           o_cmp_op,
  output logic              o_branch,
  output logic              o_jump,
  output wb_sel_e           o_wb_sel,
  output logic              o_wb_en,
  output logic [1:0]        o_lsu_size,
  output logic              o_lsu_sign_ext,
  output logic              o_lsu_we,
  output logic              o_load,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ok;
  dec_t       dec;

  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;
  logic [XLEN-1:0]   imm_d;

  logic              valid_q;
  ctl_t              ctl_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic adv;
  logic hazard;
  logic accept;
  logic hit1;
  logic hit2;

  assign opc   = i_inst[6:0];
  assign f3    = i_inst[14:12];
  assign f7    = i_inst[31:25];
  assign rs1_d = REG_AW'(i_inst[19:15]);
  assign rs2_d = REG_AW'(i_inst[24:20]);
  assign rd_d  = REG_AW'(i_inst[11:7]);

  always_comb begin
    dec = '0;
    ok  = 1'b0;
    unique case (1'b1)
      opc == OPC_LUI: begin
        ok               = 1'b1;
        dec.fmt          = IMM_U;
        dec.ctl.alu_op   = ALU_OP_ADD;
        dec.ctl.alu_sel1 = SEL1_ZERO;
        dec.ctl.alu_sel2 = SEL2_IMM;
        dec.ctl.wb_sel   = WB_ALU;
        dec.ctl.wb_en    = 1'b1;
      end
      opc == OPC_AUIPC: begin
        ok               = 1'b1;
        dec.fmt          = IMM_U;
        dec.ctl.alu_op   = ALU_OP_ADD;
        dec.ctl.alu_sel1 = SEL1_PC;
        dec.ctl.alu_sel2 = SEL2_IMM;
        dec.ctl.wb_sel   = WB_ALU;
        dec.ctl.wb_en    = 1'b1;
      end
      opc == OPC_JAL: begin
        ok               = 1'b1;
        dec.fmt          = IMM_J;
        dec.ctl.jump     = 1'b1;
        dec.ctl.alu_op   = ALU_OP_ADD;
        dec.ctl.alu_sel1 = SEL1_PC;
        dec.ctl.alu_sel2 = SEL2_IMM;
        dec.ctl.wb_sel   = WB_PC4;
        dec.ctl.wb_en    = 1'b1;
      end
      opc == OPC_JALR: begin
        ok               = (f3 == 3'd0);
        dec.fmt          = IMM_I;
        dec.uses_rs1     = 1'b1;
        dec.ctl.jump     = 1'b1;
        dec.ctl.alu_op   = ALU_OP_ADD;
        dec.ctl.alu_sel1 = SEL1_RS1;
        dec.ctl.alu_sel2 = SEL2_IMM;
        dec.ctl.wb_sel   = WB_PC4;
        dec.ctl.wb_en    = 1'b1;
      end
      opc == OPC_BRANCH: begin
        ok               = (f3 != 3'd2) && (f3 != 3'd3);
        dec.fmt          = IMM_B;
        dec.uses_rs1     = 1'b1;
        dec.uses_rs2     = 1'b1;
        dec.ctl.branch   = 1'b1;
        dec.ctl.cmp_op   = cmp_from_f3(f3);
        dec.ctl.alu_op   = ALU_OP_ADD;
        dec.ctl.alu_sel1 = SEL1_PC;
        dec.ctl.alu_sel2 = SEL2_IMM;
      end
      opc == OPC_LOAD: begin
        ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        dec.fmt              = IMM_I;
        dec.uses_rs1         = 1'b1;
        dec.ctl.load         = 1'b1;
        dec.ctl.lsu_size     = f3[1:0];
        dec.ctl.lsu_sign_ext = !f3[2];
        dec.ctl.alu_op       = ALU_OP_ADD;
        dec.ctl.alu_sel1     = SEL1_RS1;
        dec.ctl.alu_sel2     = SEL2_IMM;
        dec.ctl.wb_sel       = WB_MEM;
        dec.ctl.wb_en        = 1'b1;
      end
      opc == OPC_STORE: begin
        ok               = (f3 < 3'd3);
        dec.fmt          = IMM_S;
        dec.uses_rs1     = 1'b1;
        dec.uses_rs2     = 1'b1;
        dec.ctl.lsu_we   = 1'b1;
        dec.ctl.lsu_size = f3[1:0];
        dec.ctl.alu_op   = ALU_OP_ADD;
        dec.ctl.alu_sel1 = SEL1_RS1;
        dec.ctl.alu_sel2 = SEL2_IMM;
      end
      opc == OPC_OPIMM: begin
        // funct7 is part of the immediate except for shifts
        if (f3 == 3'd1)
          ok = (f7 == 7'h00);
        else if (f3 == 3'd5)
          ok = (f7 == 7'h00) || (f7 == 7'h20);
        else
          ok = 1'b1;
        dec.fmt          = IMM_I;
        dec.uses_rs1     = 1'b1;
        dec.ctl.alu_op   = alu_from_f3(f3,
                             (f3 == 3'd5) && i_inst[30]);
        dec.ctl.alu_sel1 = SEL1_RS1;
        dec.ctl.alu_sel2 = SEL2_IMM;
        dec.ctl.wb_sel   = WB_ALU;
        dec.ctl.wb_en    = 1'b1;
      end
      opc == OPC_OP: begin
        ok = (f7 == 7'h00) ||
             ((f7 == 7'h20) &&
              ((f3 == 3'd0) || (f3 == 3'd5)));
        dec.fmt          = IMM_NONE;
        dec.uses_rs1     = 1'b1;
        dec.uses_rs2     = 1'b1;
        dec.ctl.alu_op   = alu_from_f3(f3, i_inst[30]);
        dec.ctl.alu_sel1 = SEL1_RS1;
        dec.ctl.alu_sel2 = SEL2_RS2;
        dec.ctl.wb_sel   = WB_ALU;
        dec.ctl.wb_en    = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      dec             = '0;
      dec.ctl.illegal = 1'b1;
    end
  end

  decode_stage_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_inst (i_inst[31:7]),
    .i_fmt  (dec.fmt),
    .o_imm  (imm_d)
  );

  assign hit1 = dec.uses_rs1 && (rs1_d == rd_q);
  assign hit2 = dec.uses_rs2 && (rs2_d == rd_q);

  assign adv    = !valid_q || i_ready;
  assign hazard = (LOAD_USE_STALL != 0) && valid_q &&
                  ctl_q.load && (rd_q != '0) &&
                  i_valid && (hit1 || hit2);
  assign o_ready = adv && !hazard && !i_flush;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      ctl_q   <= CTL_NONE;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      ctl_q   <= CTL_NONE;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctl_q   <= dec.ctl;
      pc_q    <= i_pc;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end else if (adv) begin
      valid_q <= 1'b0;
      ctl_q   <= CTL_NONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      cnt_q <= '0;
    else if (hazard && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign o_valid        = valid_q;
  assign o_pc           = pc_q;
  assign o_imm          = imm_q;
  assign o_rs1          = rs1_q;
  assign o_rs2          = rs2_q;
  assign o_rd           = rd_q;
  assign o_alu_op       = ctl_q.alu_op;
  assign o_alu_sel1     = ctl_q.alu_sel1;
  assign o_alu_sel2     = ctl_q.alu_sel2;
  assign o_cmp_op       = ctl_q.cmp_op;
  assign o_branch       = ctl_q.branch;
  assign o_jump         = ctl_q.jump;
  assign o_wb_sel       = ctl_q.wb_sel;
  assign o_wb_en        = ctl_q.wb_en;
  assign o_lsu_size     = ctl_q.lsu_size;
  assign o_lsu_sign_ext = ctl_q.lsu_sign_ext;
  assign o_lsu_we       = ctl_q.lsu_we;
  assign o_load         = ctl_q.load;
  assign o_illegal      = ctl_q.illegal;
  assign o_stall_cnt    = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default build plus no-stall
// and narrow-counter builds fed from the same stimulus.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] ADD6  = 32'h00028333;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADD6Z = 32'h00000333;
  localparam logic [31:0] BEQ   = 32'hFE000CE3;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        i_ready;

  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  alu_op_e     o_alu_op;
  alu_sel1_e   o_alu_sel1;
  alu_sel2_e   o_alu_sel2;
  cmp_op_e     o_cmp_op;
  logic        o_branch, o_jump, o_wb_en;
  wb_sel_e     o_wb_sel;
  logic [1:0]  o_lsu_size;
  logic        o_lsu_sign_ext, o_lsu_we, o_load, o_illegal;
  logic [15:0] o_stall_cnt;

  logic        n_ready, n_valid;
  logic [31:0] n_pc, n_imm;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  alu_op_e     n_alu_op;
  alu_sel1_e   n_sel1;
  alu_sel2_e   n_sel2;
  cmp_op_e     n_cmp;
  logic        n_branch, n_jump, n_wb_en;
  wb_sel_e     n_wb_sel;
  logic [1:0]  n_size;
  logic        n_sext, n_we, n_load, n_illegal;
  logic [15:0] n_cnt;

  logic        s_ready, s_valid;
  logic [31:0] s_pc, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  alu_op_e     s_alu_op;
  alu_sel1_e   s_sel1;
  alu_sel2_e   s_sel2;
  cmp_op_e     s_cmp;
  logic        s_branch, s_jump, s_wb_en;
  wb_sel_e     s_wb_sel;
  logic [1:0]  s_size;
  logic        s_sext, s_we, s_load, s_illegal;
  logic [3:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  decode_stage u_dut (
    .i_clk (i_clk), .i_rst (i_rst),
    .i_valid (i_valid), .o_ready (o_ready),
    .i_inst (i_inst), .i_pc (i_pc),
    .i_flush (i_flush), .o_valid (o_valid),
    .i_ready (i_ready), .o_pc (o_pc),
    .o_rs1 (o_rs1), .o_rs2 (o_rs2), .o_rd (o_rd),
    .o_imm (o_imm), .o_alu_op (o_alu_op),
    .o_alu_sel1 (o_alu_sel1), .o_alu_sel2 (o_alu_sel2),
    .o_cmp_op (o_cmp_op), .o_branch (o_branch),
    .o_jump (o_jump), .o_wb_sel (o_wb_sel),
    .o_wb_en (o_wb_en), .o_lsu_size (o_lsu_size),
    .o_lsu_sign_ext (o_lsu_sign_ext),
    .o_lsu_we (o_lsu_we), .o_load (o_load),
    .o_illegal (o_illegal), .o_stall_cnt (o_stall_cnt)
  );

  decode_stage #(.LOAD_USE_STALL(0)) u_nos (
    .i_clk (i_clk), .i_rst (i_rst),
    .i_valid (i_valid), .o_ready (n_ready),
    .i_inst (i_inst), .i_pc (i_pc),
    .i_flush (i_flush), .o_valid (n_valid),
    .i_ready (i_ready), .o_pc (n_pc),
    .o_rs1 (n_rs1), .o_rs2 (n_rs2), .o_rd (n_rd),
    .o_imm (n_imm), .o_alu_op (n_alu_op),
    .o_alu_sel1 (n_sel1), .o_alu_sel2 (n_sel2),
    .o_cmp_op (n_cmp), .o_branch (n_branch),
    .o_jump (n_jump), .o_wb_sel (n_wb_sel),
    .o_wb_en (n_wb_en), .o_lsu_size (n_size),
    .o_lsu_sign_ext (n_sext),
    .o_lsu_we (n_we), .o_load (n_load),
    .o_illegal (n_illegal), .o_stall_cnt (n_cnt)
  );

  decode_stage #(.CNT_W(4)) u_sat (
    .i_clk (i_clk), .i_rst (i_rst),
    .i_valid (i_valid), .o_ready (s_ready),
    .i_inst (i_inst), .i_pc (i_pc),
    .i_flush (i_flush), .o_valid (s_valid),
    .i_ready (i_ready), .o_pc (s_pc),
    .o_rs1 (s_rs1), .o_rs2 (s_rs2), .o_rd (s_rd),
    .o_imm (s_imm), .o_alu_op (s_alu_op),
    .o_alu_sel1 (s_sel1), .o_alu_sel2 (s_sel2),
    .o_cmp_op (s_cmp), .o_branch (s_branch),
    .o_jump (s_jump), .o_wb_sel (s_wb_sel),
    .o_wb_en (s_wb_en), .o_lsu_size (s_size),
    .o_lsu_sign_ext (s_sext),
    .o_lsu_we (s_we), .o_load (s_load),
    .o_illegal (s_illegal), .o_stall_cnt (s_cnt)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_inst  = '0;
    i_pc    = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_wb_en", 64'(o_wb_en), 64'(0));
    check("rst_cnt", 64'(o_stall_cnt), 64'(0));
    check("rst_pc", 64'(o_pc), 64'(0));
    i_rst = 1'b0;

    i_valid = 1'b1; i_inst = ADD3;
    i_pc = 32'h100; i_ready = 1'b1;
    #1;
    check("add_ready", 64'(o_ready), 64'(1));
    cyc();
    i_valid = 1'b0;
    check("add_valid", 64'(o_valid), 64'(1));
    check("add_rs1", 64'(o_rs1), 64'(1));
    check("add_rs2", 64'(o_rs2), 64'(2));
    check("add_rd", 64'(o_rd), 64'(3));
    check("add_op", 64'(o_alu_op), 64'(ALU_OP_ADD));
    check("add_wb_en", 64'(o_wb_en), 64'(1));
    check("add_pc", 64'(o_pc), 64'(32'h100));
    cyc();
    check("idle_valid", 64'(o_valid), 64'(0));

    i_valid = 1'b1; i_inst = LW5; i_pc = 32'h104;
    cyc();
    check("lw_load", 64'(o_load), 64'(1));
    check("lw_rd", 64'(o_rd), 64'(5));
    i_inst = ADD6; i_pc = 32'h108;
    #1;
    check("lu_ready", 64'(o_ready), 64'(0));
    check("nos_ready", 64'(n_ready), 64'(1));
    cyc();
    check("lu_gap", 64'(o_valid), 64'(0));
    check("lu_cnt", 64'(o_stall_cnt), 64'(1));
    check("nos_valid", 64'(n_valid), 64'(1));
    check("nos_rd", 64'(n_rd), 64'(6));
    check("lu_ready2", 64'(o_ready), 64'(1));
    cyc();
    check("lu_valid", 64'(o_valid), 64'(1));
    check("lu_rd", 64'(o_rd), 64'(6));
    check("lu_rs1", 64'(o_rs1), 64'(5));

    i_inst = LW0; i_pc = 32'h10C;
    cyc();
    check("lw0_valid", 64'(o_valid), 64'(1));
    check("lw0_wb_en", 64'(o_wb_en), 64'(1));
    check("lw0_rd", 64'(o_rd), 64'(0));
    i_inst = ADD6Z;
    #1;
    check("x0_ready", 64'(o_ready), 64'(1));
    cyc();
    check("x0_valid", 64'(o_valid), 64'(1));
    check("x0_cnt", 64'(o_stall_cnt), 64'(1));
    i_valid = 1'b0;
    cyc();

    i_valid = 1'b1; i_inst = ADD3; i_pc = 32'h200;
    cyc();
    i_ready = 1'b0; i_inst = BEQ; i_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_valid", 64'(o_valid), 64'(1));
      check("hold_pc", 64'(o_pc), 64'(32'h200));
      check("hold_rd", 64'(o_rd), 64'(3));
      check("hold_op", 64'(o_alu_op), 64'(ALU_OP_ADD));
      check("hold_ready", 64'(o_ready), 64'(0));
      cyc();
    end
    check("hold_end", 64'(o_valid), 64'(1));
    i_flush = 1'b1;
    #1;
    check("flush_ready", 64'(o_ready), 64'(0));
    cyc();
    check("flush_valid", 64'(o_valid), 64'(0));
    i_flush = 1'b0; i_ready = 1'b1;

    i_inst = BEQ; i_pc = 32'h300;
    cyc();
    check("beq_valid", 64'(o_valid), 64'(1));
    check("beq_imm", 64'(o_imm), 64'(32'hFFFFFFF8));
    check("beq_branch", 64'(o_branch), 64'(1));
    check("beq_cmp", 64'(o_cmp_op), 64'(CMP_EQ));
    check("beq_pc", 64'(o_pc), 64'(32'h300));
    i_inst = 32'hFFFFFFFF;
    cyc();
    check("ill_flag", 64'(o_illegal), 64'(1));
    check("ill_wb_en", 64'(o_wb_en), 64'(0));
    check("ill_valid", 64'(o_valid), 64'(1));
    check("ill_branch", 64'(o_branch), 64'(0));
    i_valid = 1'b0;
    cyc();

    i_valid = 1'b1; i_inst = LW5; i_pc = 32'h400;
    cyc();
    i_ready = 1'b0; i_inst = ADD6;
    repeat (19) cyc();
    check("sat_main", 64'(o_stall_cnt), 64'(20));
    check("sat_cnt4", 64'(s_cnt), 64'(15));
    check("sat_nos", 64'(n_cnt), 64'(0));
    check("sat_held", 64'(o_valid), 64'(1));

    i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_valid", 64'(o_valid), 64'(0));
    check("arst_wb_en", 64'(o_wb_en), 64'(0));
    check("arst_cnt", 64'(o_stall_cnt), 64'(0));
    check("arst_cnt4", 64'(s_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
